moxie_ifetch_wb: RTL and testbench

Parametrised Wishbone classic instruction-fetch master with a prefetch FIFO. It sits between the core's fetch stage and the instruction-memory Wishbone port. It generalises the single free-running strobe toggle into a real master with:
- a configurable buffer depth
- back-to-back bursts of sequential reads
- branch redirect, including discard of the in-flight read
- bus error handling

---
 rtl/moxie_ifetch_wb_if.sv | 23 ++
 rtl/moxie_ifetch_wb.sv | 104 ++++++++++
 tb/tb_moxie_ifetch_wb.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/moxie_ifetch_wb_if.sv
// moxie_ifetch_wb_if: Wishbone classic instruction-port bundle
interface moxie_ifetch_wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   wb_I_adr_o;
  logic [DW-1:0]   wb_I_dat_i;
  logic [DW-1:0]   wb_I_dat_o;
  logic [DW/8-1:0] wb_I_sel_o;
  logic            wb_I_we_o;
  logic            wb_I_cyc_o;
  logic            wb_I_stb_o;
  logic            wb_I_ack_i;
  logic            wb_I_err_i;
  modport master (
    output wb_I_adr_o, wb_I_dat_o, wb_I_sel_o, wb_I_we_o, wb_I_cyc_o, wb_I_stb_o,
    input  wb_I_dat_i, wb_I_ack_i, wb_I_err_i
  );
  modport slave (
    input  wb_I_adr_o, wb_I_dat_o, wb_I_sel_o, wb_I_we_o, wb_I_cyc_o, wb_I_stb_o,
    output wb_I_dat_i, wb_I_ack_i, wb_I_err_i
  );
endinterface

// File: rtl/moxie_ifetch_wb.sv
// moxie_ifetch_wb: Wishbone classic instruction-fetch master with prefetch FIFO
module moxie_ifetch_wb #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = 'h0000_1000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  moxie_ifetch_wb_if.master wb,
  input  logic              flush_i,
  input  logic [AW-1:0]     target_i,
  output logic [DW-1:0]     data_o,
  output logic [AW-1:0]     pc_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              fault_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] STEP = AW'(DW / 8);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_t;
  state_t        state, state_n;
  logic [AW-1:0] adr, adr_n, tgt, tgt_n, tgt_a;
  logic [CW-1:0] count;
  logic [PW-1:0] rp, wp;
  logic          fault_n, ack, err, done, push, pop;
  logic [AW-1:0] pc_mem  [DEPTH];
  logic [DW-1:0] dat_mem [DEPTH];
  assign err     = wb.wb_I_err_i;
  assign ack     = wb.wb_I_ack_i & ~err;
  assign done    = ack | err;
  assign tgt_a   = {target_i[AW-1:2], 2'b00};
  assign valid_o = count != '0;
  assign pop     = valid_o & ready_i & ~flush_i;
  assign data_o  = valid_o ? dat_mem[rp] : '0;
  assign pc_o    = valid_o ? pc_mem[rp] : '0;
  assign wb.wb_I_adr_o = adr;
  assign wb.wb_I_dat_o = '0;
  assign wb.wb_I_sel_o = '1;
  assign wb.wb_I_we_o  = 1'b0;
  assign wb.wb_I_stb_o = (state == REQ) || (state == DISCARD);
  assign wb.wb_I_cyc_o = wb.wb_I_stb_o;
  // Next-state, fetch address, redirect target and push decision; flush overrides everything
  always_comb begin
    state_n = state;
    adr_n   = adr;
    tgt_n   = tgt;
    push    = 1'b0;
    fault_n = flush_i ? 1'b0 : (state == REQ && err) ? 1'b1 : fault_o;
    case (state)
      IDLE: begin
        state_n = (!flush_i && count < FULL) ? REQ : IDLE;
        adr_n   = flush_i ? tgt_a : adr;
      end
      REQ: begin
        push    = ack & ~flush_i;
        tgt_n   = flush_i ? tgt_a : tgt;
        adr_n   = flush_i ? (done ? tgt_a : adr) : ack ? adr + STEP : adr;
        state_n = flush_i ? (done ? REQ : DISCARD) :
                  err     ? HALT :
                  !ack    ? REQ :
                  (count + CW'(1) - CW'(pop) < FULL) ? REQ : IDLE;
      end
      DISCARD: begin
        tgt_n   = flush_i ? tgt_a : tgt;
        adr_n   = done ? tgt_n : adr;
        state_n = done ? REQ : DISCARD;
      end
      default: begin
        adr_n   = flush_i ? tgt_a : adr;
        state_n = flush_i ? IDLE : HALT;
      end
    endcase
  end
  // Control state, address and FIFO bookkeeping; flush empties the buffer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      adr     <= RESET_PC;
      tgt     <= RESET_PC;
      count   <= '0;
      rp      <= '0;
      wp      <= '0;
      fault_o <= 1'b0;
    end else begin
      state   <= state_n;
      adr     <= adr_n;
      tgt     <= tgt_n;
      fault_o <= fault_n;
      count   <= flush_i ? '0 : count + CW'(push) - CW'(pop);
      rp      <= flush_i ? '0 : rp + PW'(pop);
      wp      <= flush_i ? '0 : wp + PW'(push);
    end
  end
  // FIFO storage: each entry keeps the fetch address alongside the returned word
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wp]  <= adr;
      dat_mem[wp] <= wb.wb_I_dat_i;
    end
  end
endmodule

// File: tb/tb_moxie_ifetch_wb.sv
// tb_moxie_ifetch_wb: table-driven and scoreboard checks of the fetch master
module tb_moxie_ifetch_wb;
  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] target_i = '0;
  logic [31:0] data_o, pc_o;
  logic        valid_o, fault_o;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] q[$];
  bit          disc;
  typedef struct {
    logic        stb;
    logic [31:0] adr;
    logic        v;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[6];
  moxie_ifetch_wb_if #(.AW(32), .DW(32)) wb();
  moxie_ifetch_wb #(.AW(32), .DW(32), .DEPTH(4), .RESET_PC(32'h0000_1000)) dut (
    .clk_i(clk), .rst_i(rst_i), .wb(wb), .flush_i(flush_i), .target_i(target_i),
    .data_o(data_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i), .fault_o(fault_o)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction
  assign wb.wb_I_dat_i = memf(wb.wb_I_adr_o);
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  // One clock: drive slave/consumer at the negedge, score the cycle, advance to the next negedge
  task automatic tick(input bit a, input bit e, input bit rdy, input bit fl, input logic [31:0] tgt);
    logic        ackv, errv;
    logic [63:0] h;
    ready_i  = rdy;
    flush_i  = fl;
    target_i = tgt;
    wb.wb_I_ack_i = a & wb.wb_I_stb_o;
    wb.wb_I_err_i = e & wb.wb_I_stb_o;
    #1;
    ackv = wb.wb_I_ack_i & ~wb.wb_I_err_i;
    errv = wb.wb_I_err_i;
    if (fl) begin
      q.delete();
      disc = wb.wb_I_stb_o & !(ackv | errv);
    end else begin
      if (valid_o && rdy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underrun actual_pc=%h required=no_valid", pc_o);
        end else begin
          h = q.pop_front();
          chk("sb_pc", pc_o, h[63:32]);
          chk("sb_data", data_o, h[31:0]);
        end
      end
      if (wb.wb_I_stb_o && (ackv || errv)) begin
        if (disc) disc = 1'b0;
        else if (!errv) q.push_back({wb.wb_I_adr_o, memf(wb.wb_I_adr_o)});
      end
    end
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b0;
    wb.wb_I_ack_i = 1'b0;
    wb.wb_I_err_i = 1'b0;
  endtask
  task automatic do_reset();
    rst_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    wb.wb_I_ack_i = 1'b0;
    wb.wb_I_err_i = 1'b0;
    q.delete();
    disc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_stb", 32'(wb.wb_I_stb_o), 0);
    chk("rst_cyc", 32'(wb.wb_I_cyc_o), 0);
    chk("rst_adr", wb.wb_I_adr_o, 32'h1000);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_fault", 32'(fault_o), 0);
    chk("rst_data", data_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("tie_we", 32'(wb.wb_I_we_o), 0);
    chk("tie_sel", 32'(wb.wb_I_sel_o), 32'hf);
    chk("tie_dat", wb.wb_I_dat_o, 0);
    rst_i = 1'b1;
  endtask
  initial begin
    int  n;
    bit  ok;
    tbl[0] = '{1'b0, 32'h1000, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h1000, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h1004, 1'b1, 32'h1000};
    tbl[3] = '{1'b1, 32'h1008, 1'b1, 32'h1004};
    tbl[4] = '{1'b1, 32'h100c, 1'b1, 32'h1008};
    tbl[5] = '{1'b1, 32'h1010, 1'b1, 32'h100c};
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("seq%0d_stb", i), 32'(wb.wb_I_stb_o), 32'(tbl[i].stb));
      chk($sformatf("seq%0d_adr", i), wb.wb_I_adr_o, tbl[i].adr);
      chk($sformatf("seq%0d_valid", i), 32'(valid_o), 32'(tbl[i].v));
      chk($sformatf("seq%0d_pc", i), pc_o, tbl[i].pc);
      tick(1, 0, 1, 0, 0);
    end
    do_reset();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (wb.wb_I_stb_o) n++;
      tick(1, 0, 0, 0, 0);
    end
    chk("bp_acks", 32'(n), 4);
    chk("bp_stb", 32'(wb.wb_I_stb_o), 0);
    chk("bp_valid", 32'(valid_o), 1);
    tick(1, 0, 1, 0, 0);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wb.wb_I_stb_o) begin
        ok = 1'b1;
        break;
      end
      tick(0, 0, 0, 0, 0);
    end
    chk("bp_restart", 32'(ok), 1);
    chk("bp_restart_adr", wb.wb_I_adr_o, 32'h1010);
    for (int i = 0; i < 6; i++) tick(1, 0, 1, 0, 0);
    do_reset();
    tick(0, 0, 1, 0, 0);
    chk("dly_stb0", 32'(wb.wb_I_stb_o), 1);
    chk("dly_adr0", wb.wb_I_adr_o, 32'h1000);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 32'h2003);
    chk("dly_hold_stb", 32'(wb.wb_I_stb_o), 1);
    chk("dly_hold_adr", wb.wb_I_adr_o, 32'h1000);
    chk("dly_hold_valid", 32'(valid_o), 0);
    tick(0, 0, 1, 0, 0);
    chk("dly_hold2_adr", wb.wb_I_adr_o, 32'h1000);
    tick(1, 0, 1, 0, 0);
    chk("dly_tgt_stb", 32'(wb.wb_I_stb_o), 1);
    chk("dly_tgt_adr", wb.wb_I_adr_o, 32'h2000);
    chk("dly_drop_valid", 32'(valid_o), 0);
    for (int i = 0; i < 6; i++) begin
      if (valid_o) break;
      tick(1, 0, 1, 0, 0);
    end
    chk("dly_first_valid", 32'(valid_o), 1);
    chk("dly_first_pc", pc_o, 32'h2000);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0, 0);
    chk("fl_pre_valid", 32'(valid_o), 1);
    tick(1, 0, 1, 1, 32'h4000);
    chk("fl_valid", 32'(valid_o), 0);
    chk("fl_stb", 32'(wb.wb_I_stb_o), 1);
    chk("fl_adr", wb.wb_I_adr_o, 32'h4000);
    tick(0, 0, 1, 0, 0);
    chk("fl_no_underflow", 32'(valid_o), 0);
    tick(1, 0, 1, 0, 0);
    chk("fl_next_valid", 32'(valid_o), 1);
    chk("fl_next_pc", pc_o, 32'h4000);
    do_reset();
    for (int i = 0; i < 8; i++)
      tick(wb.wb_I_adr_o != 32'h1008, wb.wb_I_adr_o == 32'h1008, 0, 0, 0);
    chk("err_fault", 32'(fault_o), 1);
    chk("err_valid", 32'(valid_o), 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("err_stb%0d", i), 32'(wb.wb_I_stb_o), 0);
      tick(1, 1, 0, 0, 0);
    end
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk("err_drained", 32'(valid_o), 0);
    chk("err_fault_sticky", 32'(fault_o), 1);
    tick(0, 0, 0, 1, 32'h3000);
    chk("err_fault_clr", 32'(fault_o), 0);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wb.wb_I_stb_o) begin
        ok = 1'b1;
        break;
      end
      tick(0, 0, 0, 0, 0);
    end
    chk("err_resume", 32'(ok), 1);
    chk("err_resume_adr", wb.wb_I_adr_o, 32'h3000);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0, 0);
    chk("ar_pre_stb", 32'(wb.wb_I_stb_o), 1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("ar_stb", 32'(wb.wb_I_stb_o), 0);
    chk("ar_cyc", 32'(wb.wb_I_cyc_o), 0);
    chk("ar_valid", 32'(valid_o), 0);
    @(negedge clk);
    do_reset();
    tick(1, 0, 1, 0, 0);
    chk("ar_restart_stb", 32'(wb.wb_I_stb_o), 1);
    chk("ar_restart_adr", wb.wb_I_adr_o, 32'h1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
